// File: rtl/riscv_m_pkg.sv
// riscv_m_pkg: shared definitions for the RV32M/RV64M multiply/divide unit.
//   - funct3 encodings for the eight M-extension operations
//   - decode helpers: is_div, is_rem, a_signed, b_signed
//   - FSM state encoding shared by the unit
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Only meaningful for divide ops: selects remainder over quotient.
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational conditional two's-complement negation.
// Used both to turn signed operands into magnitudes before iterating and to
// restore the sign of the product / quotient / remainder afterwards.
// Ports:
//   value  in  W  input word
//   neg    in  1  negate when high
//   fixed  out W  neg ? -value : value (modulo 2^W)
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] fixed
);

  assign fixed = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit (one bit per cycle).
// Shift-add multiply and restoring divide run on operand magnitudes; the sign
// is restored at the end. Divide-by-zero and signed overflow finish in one cycle.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready request handshake (accept = in_valid & in_ready & !kill)
//   funct3, a, b      M-op select and rs1/rs2 operands
//   kill              pipeline flush, aborts any operation
//   out_valid/out_ready result handshake; result is registered
//   busy              high in CALC or DONE for the hazard unit
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;

  logic [2:0]      op;
  logic            neg_q;     // sign of product / quotient
  logic            neg_r;     // sign of remainder (follows a)
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] hi, lo;    // product {hi,lo} or {remainder, quotient}
  logic [CNT_W-1:0] cnt;

  // ---------------- accept-side decode ----------------
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            b_zero, sovf, fast;
  logic [XLEN-1:0] fast_res;

  assign accept = in_valid && in_ready && !kill;
  assign a_neg  = a_signed(funct3) & a[XLEN-1];
  assign b_neg  = b_signed(funct3) & b[XLEN-1];

  muldiv_sign_fix #(.W(XLEN)) u_fix_a (.value(a), .neg(a_neg), .fixed(a_abs));
  muldiv_sign_fix #(.W(XLEN)) u_fix_b (.value(b), .neg(b_neg), .fixed(b_abs));

  assign b_zero = (b == '0);
  assign sovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (a == MIN_NEG) && (b == '1);
  assign fast   = is_div(funct3) && (b_zero || sovf);

  // Divide-by-zero wins over overflow; overflow needs b == -1 so they are disjoint anyway.
  assign fast_res = b_zero ? (is_rem(funct3) ? a : '1)
                           : (is_rem(funct3) ? '0 : a);

  // ---------------- iterator step ----------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift, div_diff;
  logic [XLEN-1:0] hi_nxt, lo_nxt;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
  assign div_shift = {hi, lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_mag};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (is_div(op)) begin
      // Restoring step: keep the trial subtraction only when it did not borrow.
      if (!div_diff[XLEN]) begin
        hi_nxt = div_diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift-add step: the carry out of the add shifts into the product top.
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // ---------------- sign restore on the final step ----------------
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quo_fixed, rem_fixed;
  logic [XLEN-1:0]   final_res;

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_p (.value({hi_nxt, lo_nxt}), .neg(neg_q), .fixed(prod_fixed));
  muldiv_sign_fix #(.W(XLEN))   u_fix_q (.value(lo_nxt), .neg(neg_q), .fixed(quo_fixed));
  muldiv_sign_fix #(.W(XLEN))   u_fix_r (.value(hi_nxt), .neg(neg_r), .fixed(rem_fixed));

  always_comb begin
    final_res = '0;
    if (is_div(op))
      final_res = is_rem(op) ? rem_fixed : quo_fixed;
    else if (op == F3_MUL)
      final_res = prod_fixed[XLEN-1:0];
    else
      final_res = prod_fixed[2*XLEN-1:XLEN];
  end

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here creates order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)     state_nxt = fast ? DONE : CALC;
        CALC:    if (cnt == '0)    state_nxt = DONE;
        DONE:    if (out_ready)    state_nxt = IDLE;
        default:                   state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == CALC) || (state == DONE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_mag  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (kill) begin
      cnt <= '0;
    end else if (accept) begin
      op    <= funct3;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      b_mag <= b_abs;
      hi    <= '0;
      lo    <= a_abs;
      if (fast) result <= fast_res;
      else      cnt    <= CNT_W'(XLEN-1);
    end else if (state == CALC) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) result <= final_res;
    end
  end

endmodule
